// File: rtl/led_sweep_ctrl_if.sv
// Control/status bundle between a run scheduler (master) and the LED sweep sequencer (slave).
// Carries the start/stop request, latched run settings, busy/done status and the LED drive.
interface led_sweep_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic [1:0]       i_mode;
    logic [3:0]       i_nsweeps;
    logic             i_stop;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_led;

    modport master (
        output i_start, i_mode, i_nsweeps, i_stop,
        input  o_busy, o_done, o_led
    );

    modport slave (
        input  i_start, i_mode, i_nsweeps, i_stop,
        output o_busy, o_done, o_led
    );
endinterface

// File: rtl/led_sweep_ctrl.sv
// LED bank sequencer: plays a bounce/rotate/fill/blink pattern for a programmed number
// of sweeps (or continuously), each step held CLK_DIV clocks, with a start/busy/done handshake.
module led_sweep_ctrl #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic           i_clk,
    input  logic           i_reset,
    led_sweep_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Step index must reach 2*WIDTH-3 (bounce, WIDTH<=16).
    localparam int KW = 5;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
    localparam logic [WIDTH-1:0] ONES       = '1;

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [3:0]       nsweeps_q, nsweeps_d;
    logic [3:0]       sweep_q, sweep_d;
    logic [KW-1:0]    k_q, k_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] led_q, led_d;

    function automatic logic [KW-1:0] last_step(input logic [1:0] m);
        case (m)
            2'd0:    last_step = KW'(2 * WIDTH - 3);
            2'd3:    last_step = KW'(1);
            default: last_step = KW'(WIDTH - 1);
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] pattern(input logic [1:0] m, input logic [KW-1:0] k);
        logic [KW-1:0] pos;
        pos = (k < KW'(WIDTH)) ? k : KW'(2 * WIDTH - 2) - k;
        case (m)
            2'd0:    pattern = ONE << pos;
            2'd1:    pattern = ONE << k;
            // Shifting past WIDTH leaves zero, so the last fill step inverts to all ones.
            2'd2:    pattern = ~(ONES << (k + KW'(1)));
            default: pattern = (k == '0) ? ONES : '0;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        mode_d    = mode_q;
        nsweeps_d = nsweeps_q;
        sweep_d   = sweep_q;
        k_d       = k_q;
        presc_d   = presc_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d   = S_RUN;
                    mode_d    = bus.i_mode;
                    nsweeps_d = bus.i_nsweeps;
                    sweep_d   = '0;
                    k_d       = '0;
                    presc_d   = '0;
                end
            end
            S_RUN: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (k_q == last_step(mode_q)) begin
                        k_d     = '0;
                        sweep_d = sweep_q + 4'd1;
                        if (nsweeps_q != 4'd0 && sweep_d == nsweeps_q) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                // Stop wins over everything and merges with a coincident natural finish.
                if (bus.i_stop) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        led_d = (state_d == S_RUN) ? pattern(mode_d, k_d) : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            nsweeps_q <= '0;
            sweep_q   <= '0;
            k_q       <= '0;
            presc_q   <= '0;
            led_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            nsweeps_q <= nsweeps_d;
            sweep_q   <= sweep_d;
            k_q       <= k_d;
            presc_q   <= presc_d;
            led_q     <= led_d;
        end
    end

    assign bus.o_busy = (state_q == S_RUN);
    assign bus.o_done = (state_q == S_DONE);
    assign bus.o_led  = led_q;

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Self-checking bench for led_sweep_ctrl: two instances (CLK_DIV=4 and CLK_DIV=1) checked
// cycle by cycle against a sequence model built from the pattern rules.
module tb_led_sweep_ctrl;

    logic       clk = 1'b0;
    logic       t_reset = 1'b1;
    logic       t_start = 1'b0;
    logic [1:0] t_mode = 2'd0;
    logic [3:0] t_nsweeps = 4'd0;
    logic       t_stop = 1'b0;
    bit         sel = 1'b0;      // 0: CLK_DIV=4 instance, 1: CLK_DIV=1 instance

    int total = 0;
    int bad   = 0;

    led_sweep_ctrl_if #(.WIDTH(8)) b4 ();
    led_sweep_ctrl_if #(.WIDTH(8)) b1 ();

    assign b4.i_start   = t_start & ~sel;
    assign b4.i_stop    = t_stop  & ~sel;
    assign b4.i_mode    = t_mode;
    assign b4.i_nsweeps = t_nsweeps;
    assign b1.i_start   = t_start & sel;
    assign b1.i_stop    = t_stop  & sel;
    assign b1.i_mode    = t_mode;
    assign b1.i_nsweeps = t_nsweeps;

    led_sweep_ctrl #(.WIDTH(8), .CLK_DIV(4)) dut4 (.i_clk(clk), .i_reset(t_reset), .bus(b4));
    led_sweep_ctrl #(.WIDTH(8), .CLK_DIV(1)) dut1 (.i_clk(clk), .i_reset(t_reset), .bus(b1));

    logic [9:0] cur;   // {busy, done, led} of the selected instance
    assign cur = sel ? {b1.o_busy, b1.o_done, b1.o_led} : {b4.o_busy, b4.o_done, b4.o_led};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [9:0] observed, input logic [9:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (busy,done,led)", tag, observed, expected);
        end
    endtask

    function automatic int sweep_len(input int m);
        case (m)
            0:       return 14;
            3:       return 2;
            default: return 8;
        endcase
    endfunction

    function automatic logic [7:0] ref_pat(input int m, input int k);
        int p;
        case (m)
            0: begin
                p = (k < 8) ? k : 14 - k;
                return 8'(1 << p);
            end
            1:       return 8'(1 << k);
            2:       return 8'((1 << (k + 1)) - 1);
            default: return (k == 0) ? 8'hFF : 8'h00;
        endcase
    endfunction

    // One run from IDLE; optional mid-run start glitch, stop/reset abort, or start held into DONE.
    task automatic run_case(input string tag, input bit dsel, input int m, input int n,
                            input int glitch_at, input int abort_at, input bit abort_is_reset,
                            input bit hold_start);
        logic [7:0] exp_q[$];
        int cdiv;
        cdiv = dsel ? 1 : 4;
        for (int s = 0; s < n; s++)
            for (int k = 0; k < sweep_len(m); k++)
                for (int c = 0; c < cdiv; c++)
                    exp_q.push_back(ref_pat(m, k));

        sel       = dsel;
        t_mode    = 2'(m);
        t_nsweeps = 4'(n);
        t_start   = 1'b1;
        tick();
        t_start   = 1'b0;

        for (int i = 0; i < exp_q.size(); i++) begin
            check(tag, cur, {2'b10, exp_q[i]});
            if (i == glitch_at) begin
                t_start = 1'b1;
                t_mode  = 2'(m + 1);
            end else begin
                t_start = 1'b0;
                t_mode  = 2'(m);
            end
            if (hold_start && i == exp_q.size() - 1) t_start = 1'b1;
            if (i == abort_at) begin
                if (abort_is_reset) t_reset = 1'b1;
                else                t_stop  = 1'b1;
            end
            tick();
            if (i == abort_at) break;
        end
        t_stop = 1'b0;

        if (abort_is_reset && abort_at >= 0) begin
            check({tag, "_reset"}, cur, 10'h000);
            t_reset = 1'b0;
            return;
        end

        check({tag, "_done"}, cur, {2'b01, 8'h00});
        tick();
        check({tag, "_idle"}, cur, 10'h000);
        if (hold_start) begin
            tick();
            check({tag, "_restart"}, cur, {2'b10, ref_pat(m, 0)});
            t_start = 1'b0;
            t_reset = 1'b1;
            tick();
            check({tag, "_clean"}, cur, 10'h000);
            t_reset = 1'b0;
        end
        tick();
    endtask

    initial begin
        int m, n, len;
        bit d;

        tick();
        tick();
        sel = 1'b0;
        check("reset4", cur, 10'h000);
        sel = 1'b1;
        check("reset1", cur, 10'h000);
        t_reset = 1'b0;
        tick();

        // Directed pattern runs.
        run_case("bounce", 1'b0, 0, 1, -1, -1, 1'b0, 1'b0);
        run_case("fill2",  1'b1, 2, 2, -1, -1, 1'b0, 1'b0);
        run_case("rotate", 1'b1, 1, 1, -1, -1, 1'b0, 1'b0);
        run_case("blink3", 1'b0, 3, 3, -1, -1, 1'b0, 1'b0);

        // Continuous bounce for 200+ cycles, then stop with prescaler at 2.
        sel = 1'b0;
        t_mode = 2'd0;
        t_nsweeps = 4'd0;
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        for (int c = 0; c <= 202; c++) begin
            check("cont", cur, {2'b10, ref_pat(0, (c / 4) % 14)});
            if (c == 202) t_stop = 1'b1;
            tick();
        end
        t_stop = 1'b0;
        check("cont_stop", cur, {2'b01, 8'h00});
        tick();
        check("cont_idle", cur, 10'h000);
        tick();

        // Ignored and coincident events.
        run_case("glitch",    1'b0, 1, 1, 5, -1, 1'b0, 1'b0);
        run_case("hold",      1'b1, 3, 1, -1, -1, 1'b0, 1'b1);
        run_case("stop_last", 1'b0, 2, 1, -1, 8 * 4 - 1, 1'b0, 1'b0);

        // Reset during the second sweep at step 5, then a fresh two-sweep run.
        run_case("rst_mid", 1'b0, 0, 2, -1, 14 * 4 + 20, 1'b1, 1'b0);
        tick();
        run_case("after_rst", 1'b0, 0, 2, -1, -1, 1'b0, 1'b0);

        // Randomized runs, some cut short by stop.
        for (int r = 0; r < 8; r++) begin
            d   = 1'($urandom_range(0, 1));
            m   = int'($urandom_range(0, 3));
            n   = int'($urandom_range(1, 4));
            len = n * sweep_len(m) * (d ? 1 : 4);
            if ($urandom_range(0, 2) == 0)
                run_case("rand_stop", d, m, n, -1, int'($urandom_range(0, len - 1)), 1'b0, 1'b0);
            else
                run_case("rand", d, m, n, int'($urandom_range(0, len - 1)), -1, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_sweep_ctrl.md
Name: led_sweep_ctrl

Overview:
- Sequencer for the board LED bank: generates a timed LED pattern from a selectable mode, runs for a programmed number of sweeps or continuously, and reports completion.
- Sits between control logic (buttons, a bus register, or a test FSM) and the LED pins.
- A programmable prescaler sets how many clocks each pattern step is held.
- A start/busy/done handshake lets a master schedule pattern runs.

Parameters:
- WIDTH, 8, number of LEDs. Legal range is 2..16.
- CLK_DIV, 4, clocks per pattern step. Must be ≥1; 1 means one step per clock.

Ports:
- i_clk  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  request a run; accepted only in IDLE
- i_mode  in  2  pattern select, latched at start: 0 bounce, 1 rotate, 2 fill, 3 blink
- i_nsweeps  in  4  sweep count, latched at start; 0 = run continuously until i_stop
- i_stop  in  1  abort the current run; honoured only in RUN
- o_busy  out  1  high while in RUN
- o_done  out  1  one-cycle pulse when a run ends, whether by completion or by stop
- o_led  out  WIDTH  registered LED drive

Behaviour:
- Reset: synchronous, active-high.
  - Clock port is i_clk; reset port is i_reset.
  - On reset: state IDLE, o_led=0, o_busy=0, o_done=0, and all counters cleared.
  - Reset takes priority over every other input, including mid-run; the edge after i_reset=1 shows IDLE outputs.
- States: IDLE, RUN, DONE.
- IDLE:
  - Outputs: o_led=0, o_busy=0.
  - i_start=1 at an edge latches i_mode and i_nsweeps, clears step index k, prescaler and sweep counter, and enters RUN.
  - Immediately after that edge: o_busy=1 and o_led=pattern(0).
- RUN:
  - Prescaler counts 0..CLK_DIV-1 and wraps.
  - On the terminal count, k advances; each pattern step is therefore visible for exactly CLK_DIV cycles.
  - On the terminal count at the last k of a sweep: k wraps to 0 and the sweep counter increments.
  - If latched nsweeps≠0 and the count reaches nsweeps, go to DONE.
  - Busy duration for a finite run is exactly nsweeps·L·CLK_DIV cycles, where L is the sweep length.
  - i_start is ignored in RUN; latched mode and count do not change.
- Patterns (L = steps per sweep):
  - bounce, L=2·WIDTH-2: position p=k for k<WIDTH, else 2·WIDTH-2-k; o_led=1<<p. For WIDTH=8: 01,02,04,08,10,20,40,80,40,20,10,08,04,02.
  - rotate, L=WIDTH: o_led=1<<k.
  - fill, L=WIDTH: o_led=(2^(k+1))-1. For WIDTH=8: 01,03,07,…,FF.
  - blink, L=2: all ones, then all zeros.
- i_stop in RUN: the next edge enters DONE regardless of prescaler or step.
  - If i_stop coincides with natural completion, DONE is entered once and o_done pulses once.
- DONE: lasts exactly one cycle.
  - Outputs: o_done=1, o_busy=0, o_led=0.
  - Always returns to IDLE; i_start during DONE is ignored.
  - The earliest restart is i_start sampled in the following IDLE cycle.
- Continuous mode (nsweeps=0) never self-terminates; the sweep counter may wrap freely.
- Undefined i_mode values do not exist; all 2-bit codes are defined.

Test Plan:
- Bounce timing: WIDTH=8, CLK_DIV=4, mode 0, nsweeps=1, start pulse → o_led = 01,02,04,08,10,20,40,80,40,20,10,08,04,02, each held 4 cycles; o_busy high for exactly 56 cycles; then one cycle o_done=1 with o_led=00; then IDLE.
- Fill and rotate: CLK_DIV=1, mode 2, nsweeps=2 → 01,03,07,0F,1F,3F,7F,FF repeated twice; busy 16 cycles; single done pulse. Mode 1, nsweeps=1 → 01,02,…,80 over 8 cycles.
- Blink multi-sweep: CLK_DIV=4, mode 3, nsweeps=3 → FF(4 cycles),00(4 cycles) ×3; busy 24 cycles; done pulse.
- Continuous plus stop: nsweeps=0, mode 0, run 200 cycles → no o_done. Assert i_stop mid-step (prescaler=2) → next cycle o_done=1, o_led=00; then IDLE.
- Ignored and coincident events:
  - i_start pulsed mid-RUN with a different mode → pattern and duration unchanged.
  - i_start held high through DONE → the new run begins only from IDLE.
  - i_stop asserted on the final terminal count → exactly one done pulse.
- Reset mid-run: assert i_reset at step 5 of bounce → next edge o_led=00, o_busy=0, o_done=0. A following start runs from pattern(0) with a fresh sweep count.
